// File: rtl/config_div_pkg.sv
// Shared types and helpers for the configurable shift-subtract divider.
// Contents:
//   div_state_e : divider FSM states
//   MAG_W       : working width of the generic magnitude helper
//   cnt_width() : width of the iteration counter for a given dividend width
//   magnitude() : absolute value of a width-bit field, or a pass-through in unsigned mode
package config_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam int unsigned MAG_W = 64;

  // Counter counts down from n-1 to 0; keep at least one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Magnitude of the low 'width' bits of value, treated as two's complement
  // when is_signed is set. Bits above 'width' in the result are cleared.
  function automatic logic [MAG_W-1:0] magnitude(input logic [MAG_W-1:0] value,
                                                 input int unsigned      width,
                                                 input logic             is_signed);
    logic [MAG_W-1:0] mask;
    logic             neg;
    mask = (MAG_W'(1) << width) - MAG_W'(1);
    neg  = is_signed && ((value & (MAG_W'(1) << (width - 1))) != '0);
    return (neg ? (~value + MAG_W'(1)) : value) & mask;
  endfunction

endpackage

// File: rtl/config_shiftsub_step.sv
// One restoring-division iteration (purely combinational).
// Ports:
//   prem          : current partial remainder (lengthDivisor+1 bits)
//   next_bit      : next dividend bit, MSB first
//   divisor_mag   : |divisor|
//   prem_next_c   : partial remainder after shift and conditional subtract
//   q_bit_c       : quotient bit produced by this iteration
module config_shiftsub_step
  import config_div_pkg::*;
#(
  parameter int unsigned lengthDivisor = 4
) (
  input  logic [lengthDivisor:0]   prem,
  input  logic                     next_bit,
  input  logic [lengthDivisor-1:0] divisor_mag,
  output logic [lengthDivisor:0]   prem_next_c,
  output logic                     q_bit_c
);

  localparam int unsigned LS = lengthDivisor;

  logic [LS:0] shifted;
  logic [LS:0] dvs_ext;

  // prem < |divisor| between iterations, so the shift never overflows LS+1 bits.
  assign shifted     = (prem << 1) | (LS + 1)'(next_bit);
  assign dvs_ext     = {1'b0, divisor_mag};
  assign q_bit_c     = (shifted >= dvs_ext);
  assign prem_next_c = q_bit_c ? (shifted - dvs_ext) : shifted;

endmodule

// File: rtl/config_shiftsub_divider.sv
// Iterative restoring divider: wide dividend / narrow divisor -> quotient and
// remainder, one quotient bit per cycle, runtime signed/unsigned selection.
// Ports:
//   clk, rst_n              : clock (rising edge), async active-low reset
//   in_valid / in_ready     : operand handshake (is_signed, dividend, divisor)
//   out_valid / out_ready   : result handshake (quotient, remainder, div_by_zero)
//   quotient                : truncated toward zero
//   remainder               : sign follows the dividend in signed mode
//   div_by_zero             : result produced from a zero divisor
module config_shiftsub_divider
  import config_div_pkg::*;
#(
  parameter int unsigned lengthDividend = 8,
  parameter int unsigned lengthDivisor  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      is_signed,
  input  logic [lengthDividend-1:0] dividend,
  input  logic [lengthDivisor-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [lengthDividend-1:0] quotient,
  output logic [lengthDivisor-1:0]  remainder,
  output logic                      div_by_zero
);

  localparam int unsigned LD = lengthDividend;
  localparam int unsigned LS = lengthDivisor;
  localparam int unsigned CW = cnt_width(LD);

  div_state_e  state;
  logic [CW-1:0] cnt;
  logic        loaded;     // magnitudes registered for the current division
  logic        sign_mode;
  logic [LD-1:0] dvd_raw;
  logic [LS-1:0] dvs_raw;
  logic [LS-1:0] dvs_mag;
  logic [LD-1:0] work;     // dividend bits leave at the MSB, quotient bits enter at the LSB
  logic [LS:0]   prem;

  logic [LS:0]   prem_next_c;
  logic          q_bit_c;
  logic          dvd_neg_c;
  logic          dvs_neg_c;
  logic [LD-1:0] dvd_mag_c;
  logic [LS-1:0] dvs_mag_c;

  // Operand signs and magnitudes, derived from the latched operands.
  assign dvd_neg_c = sign_mode & dvd_raw[LD-1];
  assign dvs_neg_c = sign_mode & dvs_raw[LS-1];
  assign dvd_mag_c = LD'(magnitude(MAG_W'(dvd_raw), LD, sign_mode));
  assign dvs_mag_c = LS'(magnitude(MAG_W'(dvs_raw), LS, sign_mode));

  config_shiftsub_step #(
    .lengthDivisor (LS)
  ) u_step (
    .prem        (prem),
    .next_bit    (work[LD-1]),
    .divisor_mag (dvs_mag),
    .prem_next_c (prem_next_c),
    .q_bit_c     (q_bit_c)
  );

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      loaded      <= 1'b0;
      sign_mode   <= 1'b0;
      dvd_raw     <= '0;
      dvs_raw     <= '0;
      dvs_mag     <= '0;
      work        <= '0;
      prem        <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_mode <= is_signed;
            dvd_raw   <= dividend;
            dvs_raw   <= divisor;
            cnt       <= CW'(LD - 1);
            loaded    <= 1'b0;
            in_ready  <= 1'b0;
            state     <= CALC;
          end
        end

        CALC: begin
          if (!loaded) begin
            // First cycle: resolve divide-by-zero, else register magnitudes so
            // the negation stays off the iteration path.
            if (dvs_raw == '0) begin
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              work        <= dvd_mag_c;
              dvs_mag     <= dvs_mag_c;
              prem        <= '0;
              div_by_zero <= 1'b0;
              loaded      <= 1'b1;
            end
          end else begin
            work <= (work << 1) | LD'(q_bit_c);
            prem <= prem_next_c;
            if (cnt == '0) begin
              state <= FIX;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end

        FIX: begin
          // Unsigned mode has both sign flags clear, so values pass through.
          quotient  <= (dvd_neg_c ^ dvs_neg_c) ? -work : work;
          remainder <= dvd_neg_c ? -prem[LS-1:0] : prem[LS-1:0];
          out_valid <= 1'b1;
          state     <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_config_shiftsub_divider.sv
// Self-checking bench for config_shiftsub_divider (8-bit dividend, 4-bit divisor).
module tb_config_shiftsub_divider;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       is_signed;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_cmp;
  int n_bad;

  config_shiftsub_divider #(
    .lengthDividend (8),
    .lengthDivisor  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       s;
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       d;
    int         hold;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain integer division (truncates toward zero, remainder takes
  // the dividend's sign), then truncated to the port widths.
  task automatic ref_div(input logic s, input logic [7:0] a, input logic [3:0] b,
                         output logic [7:0] q, output logic [3:0] r, output logic d);
    int sa;
    int sb;
    if (b == 4'd0) begin
      q = 8'hFF;
      r = 4'h0;
      d = 1'b1;
    end else begin
      if (s) begin
        sa = int'($signed(a));
        sb = int'($signed(b));
      end else begin
        sa = int'(a);
        sb = int'(b);
      end
      q = 8'(sa / sb);
      r = 4'(sa % sb);
      d = 1'b0;
    end
  endtask

  // Issue one division, check latency/result, optionally back-pressure, then drain.
  // Entered and left at #1 after a rising edge.
  task automatic run_div(input logic s, input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] eq, input logic [3:0] er, input logic ed,
                         input int hold, input string tag);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    is_signed = s;
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    is_signed = 1'($urandom);
    dividend  = 8'($urandom);
    divisor   = 4'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), (b == 4'd0) ? 32'd1 : 32'd10);
    chk({tag, " quotient"}, 32'(quotient), 32'(eq));
    chk({tag, " remainder"}, 32'(remainder), 32'(er));
    chk({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ed));
    for (int i = 0; i < hold; i++) begin
      in_valid = ((i % 2) == 0);
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
      @(posedge clk); #1;
      chk({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, " hold quotient"}, 32'(quotient), 32'(eq));
      chk({tag, " hold remainder"}, 32'(remainder), 32'(er));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " drain out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " drain in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] eq;
    logic [3:0] er;
    logic       ed;
    logic       s;
    logic [7:0] a;
    logic [3:0] b;

    n_cmp = 0;
    n_bad = 0;

    //          s     a      b      q      r      d   hold
    vecs[0] = '{1'b0, 8'd200, 4'd7, 8'd28,  4'd4,  1'b0, 0};
    vecs[1] = '{1'b1, 8'h9C, 4'h7, 8'hF2,  4'hE,  1'b0, 0};
    vecs[2] = '{1'b1, 8'd100, 4'h9, 8'hF2,  4'h2,  1'b0, 0};
    vecs[3] = '{1'b0, 8'd37, 4'd0, 8'hFF,  4'h0,  1'b1, 0};
    vecs[4] = '{1'b0, 8'd200, 4'd7, 8'd28,  4'd4,  1'b0, 0};
    vecs[5] = '{1'b1, 8'h80, 4'hF, 8'h80,  4'h0,  1'b0, 0};
    vecs[6] = '{1'b0, 8'd255, 4'd15, 8'd17, 4'd0,  1'b0, 0};
    vecs[7] = '{1'b0, 8'd5,  4'd9, 8'd0,   4'd5,  1'b0, 0};
    vecs[8] = '{1'b0, 8'h9C, 4'd7, 8'd22,  4'd2,  1'b0, 6};
    vecs[9] = '{1'b1, 8'h81, 4'h8, 8'h0F,  4'h9,  1'b0, 2};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    is_signed = 1'b0;
    dividend  = 8'd0;
    divisor   = 4'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset quotient", 32'(quotient), 32'd0);
    chk("reset remainder", 32'(remainder), 32'd0);
    chk("reset div_by_zero", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_div(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].d,
              vecs[i].hold, $sformatf("vec%0d", i));
    end

    // Reset in the middle of an iteration sequence, then a clean division.
    is_signed = 1'b0;
    dividend  = 8'd200;
    divisor   = 4'd7;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", 32'(out_valid), 32'd0);
    chk("midreset in_ready", 32'(in_ready), 32'd1);
    chk("midreset quotient", 32'(quotient), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_div(1'b0, 8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 0, "post-reset");

    // Randomized operands against the reference model.
    for (int i = 0; i < 60; i++) begin
      s = 1'($urandom);
      a = 8'($urandom);
      b = 4'($urandom);
      ref_div(s, a, b, eq, er, ed);
      run_div(s, a, b, eq, er, ed, int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
